// File: rtl/led_fade_sequencer.sv
// Linear RGB fade sequencer: ramps three 8-bit PWM duties to a commanded colour, holds, then pulses done.
// Optional build macro LED_GAMMA_EN adds a registered (x*x+255)>>8 gamma stage on the PWM outputs.
module led_fade_sequencer #(
    parameter int CLK_DIV = 48000
) (
    input  logic        clk48,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_color,
    input  logic [7:0]  cmd_rate,
    input  logic [7:0]  cmd_hold,
    input  logic        cmd_abort,
    output logic [7:0]  pwm_dc_r,
    output logic [7:0]  pwm_dc_g,
    output logic [7:0]  pwm_dc_b,
    output logic        busy,
    output logic        done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FADE = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      rate_q, rate_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      rate_cnt_q, rate_cnt_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic [2:0][7:0] tgt_q, tgt_d;
    logic [2:0][7:0] duty_q, duty_d;
    logic            cmd_ready_q, busy_q, done_q, done_d;
    logic            tick_s, accept_s, at_tgt_s;
    logic [2:0][7:0] pwm_s;

    // One LSB toward the target; a channel already at target never moves, so no wrap is possible.
    function automatic logic [7:0] step8(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] res;
        if (cur < tgt) begin
            res = cur + 8'd1;
        end else if (cur > tgt) begin
            res = cur - 8'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    assign tick_s   = (presc_q == PS_LAST);
    assign accept_s = cmd_valid && (state_q == ST_IDLE);
    assign at_tgt_s = (duty_q == tgt_q);

    // Fade-tick prescaler, restarted on every accepted command.
    always_comb begin
        presc_d = presc_q;
        if (accept_s) begin
            presc_d = '0;
        end else if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Next-state, counters, targets and linear duties.
    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        hold_d     = hold_q;
        rate_cnt_d = rate_cnt_q;
        hold_cnt_d = hold_cnt_q;
        tgt_d      = tgt_q;
        duty_d     = duty_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    tgt_d      = cmd_color;
                    rate_d     = cmd_rate;
                    hold_d     = cmd_hold;
                    rate_cnt_d = 8'd0;
                    if (cmd_color == duty_q) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = cmd_hold;
                    end else begin
                        state_d = ST_FADE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FADE: begin
                if (cmd_abort) begin
                    state_d = ST_IDLE;
                end else if (at_tgt_s) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = hold_q;
                end else if (tick_s) begin
                    if (rate_cnt_q == rate_q) begin
                        rate_cnt_d = 8'd0;
                        for (int c = 0; c < 3; c++) begin
                            duty_d[c] = step8(duty_q[c], tgt_q[c]);
                        end
                    end else begin
                        rate_cnt_d = rate_cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_FADE;
                end
            end
            ST_HOLD: begin
                if (cmd_abort) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    if (hold_cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs are registered from the next state.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            rate_q      <= 8'd0;
            hold_q      <= 8'd0;
            rate_cnt_q  <= 8'd0;
            hold_cnt_q  <= 8'd0;
            tgt_q       <= '0;
            duty_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            rate_q      <= rate_d;
            hold_q      <= hold_d;
            rate_cnt_q  <= rate_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            tgt_q       <= tgt_d;
            duty_q      <= duty_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
        end
    end

`ifdef LED_GAMMA_EN
    logic [2:0][7:0] gamma_q;

    // Square-law approximation; max x*x+255 is 65280, so 16 bits never overflow.
    function automatic logic [7:0] gamma8(input logic [7:0] x);
        logic [15:0] sq;
        sq = ({8'd0, x} * {8'd0, x}) + 16'd255;
        return sq[15:8];
    endfunction

    // Gamma stage: one extra cycle of output latency on the duties only.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            gamma_q <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                gamma_q[c] <= gamma8(duty_q[c]);
            end
        end
    end

    assign pwm_s = gamma_q;
`else
    assign pwm_s = duty_q;
`endif

    assign pwm_dc_r  = pwm_s[2];
    assign pwm_dc_g  = pwm_s[1];
    assign pwm_dc_b  = pwm_s[0];
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
